// File: rtl/insn_fetch_decode.sv
// Fetches opcode (+ optional immediate) bytes over mem req/ack, decodes them and issues to execute.
// Zero-wait latency: valid 1 cycle after the opcode fetch (2 with imm); outputs hold while !insn_ready.
module insn_fetch_decode #(
  parameter int                ADDR_W     = 8,
  parameter int                INSN_COUNT = 12,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_rdata,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  output logic [INSN_COUNT-1:0] insn_en,
  output logic [2:0]            insn_reg,
  output logic [7:0]            insn_imm,
  output logic                  insn_has_imm,
  output logic [ADDR_W-1:0]     insn_pc,
  output logic                  insn_illegal,
  input  logic                  redirect_en,
  input  logic [ADDR_W-1:0]     redirect_addr
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] FETCH_OP  = 2'd1;
  localparam logic [1:0] FETCH_IMM = 2'd2;
  localparam logic [1:0] ISSUE     = 2'd3;

  typedef struct packed {
    logic [INSN_COUNT-1:0] en;
    logic [2:0]            rsel;
    logic [7:0]            imm;
    logic                  has_imm;
    logic [ADDR_W-1:0]     pc;
    logic                  illegal;
  } dec_t;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              flush_pending_q, flush_pending_d;
  logic [7:0]        op_q, op_d;
  logic [ADDR_W-1:0] op_pc_q, op_pc_d;
  dec_t              dec_q, dec_d;

  function automatic dec_t decode(input logic [7:0] b, input logic [7:0] imm,
                                  input logic [ADDR_W-1:0] pc);
    dec_t d;
    d = '0;
    for (int i = 0; i < INSN_COUNT; i++) begin
      d.en[i] = (b[7:4] == 4'(i));
    end
    d.illegal = ({1'b0, b[7:4]} >= 5'(INSN_COUNT));
    d.rsel    = b[2:0];
    d.has_imm = b[3];
    d.imm     = b[3] ? imm : 8'h00;
    d.pc      = pc;
    return d;
  endfunction

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    tgt_d           = tgt_q;
    flush_pending_d = flush_pending_q;
    op_d            = op_q;
    op_pc_d         = op_pc_q;
    dec_d           = dec_q;
    case (state_q)
      IDLE: begin
        if (redirect_en) pc_d = redirect_addr;
        state_d = FETCH_OP;
      end
      FETCH_OP, FETCH_IMM: begin
        // The request address must stay put until ack, so a redirect target waits in tgt_q.
        if (mem_ack && (flush_pending_q || redirect_en)) begin
          pc_d            = redirect_en ? redirect_addr : tgt_q;
          flush_pending_d = 1'b0;
          state_d         = FETCH_OP;
        end else if (redirect_en) begin
          tgt_d           = redirect_addr;
          flush_pending_d = 1'b1;
        end else if (mem_ack) begin
          pc_d = pc_q + ADDR_W'(1);
          if (state_q == FETCH_OP) begin
            op_d    = mem_rdata;
            op_pc_d = pc_q;
            if (mem_rdata[3]) begin
              state_d = FETCH_IMM;
            end else begin
              dec_d   = decode(mem_rdata, 8'h00, pc_q);
              state_d = ISSUE;
            end
          end else begin
            dec_d   = decode(op_q, mem_rdata, op_pc_q);
            state_d = ISSUE;
          end
        end
      end
      default: begin
        // Accept and redirect together: the instruction is consumed, the target is fetched next.
        if (redirect_en || insn_ready) begin
          if (redirect_en) pc_d = redirect_addr;
          dec_d   = '0;
          state_d = FETCH_OP;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      pc_q            <= RESET_PC;
      tgt_q           <= '0;
      flush_pending_q <= 1'b0;
      op_q            <= '0;
      op_pc_q         <= '0;
      dec_q           <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      tgt_q           <= tgt_d;
      flush_pending_q <= flush_pending_d;
      op_q            <= op_d;
      op_pc_q         <= op_pc_d;
      dec_q           <= dec_d;
    end
  end

  assign mem_req      = (state_q == FETCH_OP) || (state_q == FETCH_IMM);
  assign mem_addr     = pc_q;
  assign insn_valid   = (state_q == ISSUE);
  assign insn_en      = dec_q.en;
  assign insn_reg     = dec_q.rsel;
  assign insn_imm     = dec_q.imm;
  assign insn_has_imm = dec_q.has_imm;
  assign insn_pc      = dec_q.pc;
  assign insn_illegal = dec_q.illegal;

endmodule

// File: tb/tb_insn_fetch_decode.sv
// Bench for insn_fetch_decode: byte-array program model, random-latency memory, accept scoreboard.
module tb_insn_fetch_decode;
  localparam int                ADDR_W     = 8;
  localparam int                INSN_COUNT = 12;
  localparam logic [ADDR_W-1:0] RESET_PC   = 8'h00;

  typedef struct packed {
    logic [INSN_COUNT-1:0] en;
    logic [2:0]            rsel;
    logic [7:0]            imm;
    logic                  has_imm;
    logic [ADDR_W-1:0]     pc;
    logic                  illegal;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  mem_req;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_ack = 1'b0;
  logic [7:0]            mem_rdata = 8'h00;
  logic                  insn_valid;
  logic                  insn_ready = 1'b0;
  logic [INSN_COUNT-1:0] insn_en;
  logic [2:0]            insn_reg;
  logic [7:0]            insn_imm;
  logic                  insn_has_imm;
  logic [ADDR_W-1:0]     insn_pc;
  logic                  insn_illegal;
  logic                  redirect_en = 1'b0;
  logic [ADDR_W-1:0]     redirect_addr = '0;

  int checks = 0;
  int failures = 0;
  int accepted = 0;
  int wait_lo = 0;
  int wait_hi = 0;
  logic [7:0] mem [0:255];
  exp_t exp_q[$];

  insn_fetch_decode #(.ADDR_W(ADDR_W), .INSN_COUNT(INSN_COUNT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn_en(insn_en), .insn_reg(insn_reg),
    .insn_imm(insn_imm), .insn_has_imm(insn_has_imm), .insn_pc(insn_pc), .insn_illegal(insn_illegal),
    .redirect_en(redirect_en), .redirect_addr(redirect_addr)
  );

  always #5 clk = ~clk;

  function automatic exp_t ref_insn(input logic [7:0] pc);
    exp_t e;
    logic [7:0] b;
    logic [7:0] nxt;
    int op;
    b   = mem[pc];
    nxt = pc + 8'd1;
    op  = int'(b[7:4]);
    e = '0;
    e.pc      = pc;
    e.rsel    = b[2:0];
    e.has_imm = b[3];
    e.imm     = b[3] ? mem[nxt] : 8'h00;
    e.illegal = (op >= INSN_COUNT);
    e.en      = e.illegal ? '0 : (INSN_COUNT'(1) << op);
    return e;
  endfunction

  function automatic logic [7:0] next_pc(input logic [7:0] pc);
    logic [7:0] b;
    b = mem[pc];
    return b[3] ? pc + 8'd2 : pc + 8'd1;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Memory responder: each new request gets a latency drawn from [wait_lo, wait_hi].
  int wait_left = 0;
  bit in_beat = 0;
  initial forever begin
    @(posedge clk); #1;
    if (mem_req) begin
      if (!in_beat) begin
        wait_left = int'($urandom_range(wait_hi, wait_lo));
        in_beat = 1;
      end
      if (wait_left == 0) begin
        mem_ack = 1'b1; mem_rdata = mem[mem_addr]; in_beat = 0;
      end else begin
        mem_ack = 1'b0; mem_rdata = 8'($urandom); wait_left--;
      end
    end else begin
      mem_ack = 1'b0; in_beat = 0;
    end
  end

  // Reference model: the next accepted instruction starts at model_pc; any redirect restarts there.
  bit fresh = 1;
  logic [7:0] model_pc = RESET_PC;
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete(); model_pc = RESET_PC; fresh = 1;
    end else if (redirect_en) begin
      exp_q.delete(); model_pc = redirect_addr; exp_q.push_back(ref_insn(model_pc)); fresh = 0;
    end else if (fresh) begin
      exp_q.push_back(ref_insn(model_pc)); fresh = 0;
    end else if (exp_q.size() == 0) begin
      model_pc = next_pc(model_pc); exp_q.push_back(ref_insn(model_pc));
    end
  end

  exp_t got, e, snap;
  logic hold_prev = 0;
  logic req_wait_prev = 0;
  logic [7:0] addr_prev = '0;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      got = {insn_en, insn_reg, insn_imm, insn_has_imm, insn_pc, insn_illegal};
      if (!insn_valid) check("en_zero_idle", 64'(insn_en), 64'd0);
      if (hold_prev) begin
        check("hold_valid", 64'(insn_valid), 64'd1);
        check("hold_fields", 64'(got), 64'(snap));
      end
      if (req_wait_prev) check("req_held", 64'({mem_req, mem_addr}), 64'({1'b1, addr_prev}));
      if (insn_valid && insn_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL accept_unexpected got pc=%0h exp none", insn_pc);
        end else begin
          e = exp_q.pop_front();
          check("accept_insn", 64'(got), 64'(e));
        end
        accepted++;
      end
      hold_prev     = insn_valid && !insn_ready && !redirect_en;
      snap          = got;
      req_wait_prev = mem_req && !mem_ack;
      addr_prev     = mem_addr;
    end else begin
      hold_prev = 0; req_wait_prev = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_req_addr(input logic [7:0] a, input string name);
    int n = 0;
    @(negedge clk);
    while (!(mem_req && mem_addr == a) && n < 200) begin @(negedge clk); n++; end
    check(name, 64'({mem_req, mem_addr}), 64'({1'b1, a}));
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!insn_valid && n < 200) begin @(negedge clk); n++; end
    check(name, 64'(insn_valid), 64'd1);
  endtask

  task automatic park();
    tick(); insn_ready = 1'b0;
    wait_valid("park_valid");
  endtask

  task automatic redirect(input logic [7:0] a);
    tick(); redirect_en = 1'b1; redirect_addr = a;
    tick(); redirect_en = 1'b0;
  endtask

  initial begin
    int n;
    bit seen_valid;
    int acc0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h25; mem[8'h04] = 8'h3A; mem[8'h05] = 8'h7F;
    mem[8'h06] = 8'hD0; mem[8'h10] = 8'h25; mem[8'hFF] = 8'h1B;

    @(negedge clk); @(negedge clk);
    check("reset_outputs", 64'({mem_req, insn_valid, insn_en, insn_has_imm, insn_illegal,
                                insn_pc, mem_addr, insn_imm, insn_reg}), 64'd0);
    tick(); rst_n = 1'b1; insn_ready = 1'b1;

    // Zero-wait single-byte instruction at 0
    wait_req_addr(8'h00, "t1_first_req");
    @(negedge clk);
    check("t1_latency", 64'(insn_valid), 64'd1);
    check("t1_fields", 64'({insn_en, insn_reg, insn_has_imm, insn_pc}), 64'({12'h004, 3'd5, 1'b0, 8'h00}));
    tick(); insn_ready = 1'b0;
    @(negedge clk);
    check("t1_next_addr", 64'({mem_req, mem_addr}), 64'({1'b1, 8'h01}));

    // Backpressure on the instruction at 1
    wait_valid("t3_valid");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_stall", 64'({insn_valid, mem_req, insn_en, insn_reg, insn_imm, insn_has_imm, insn_pc, insn_illegal}),
            64'({1'b1, 1'b0, 12'h001, 3'd0, 8'h00, 1'b0, 8'h01, 1'b0}));
    end
    tick(); insn_ready = 1'b1;
    tick(); insn_ready = 1'b0;
    @(negedge clk);
    check("t3_refetch", 64'({mem_req, mem_addr}), 64'({1'b1, 8'h02}));

    // Two-byte instruction at 4 with two wait cycles per beat
    wait_lo = 2; wait_hi = 2;
    park();
    redirect(8'h04);
    n = 0; @(negedge clk);
    while (mem_req && mem_addr == 8'h04 && n < 50) begin n++; @(negedge clk); end
    check("t2_hold4", 64'(n), 64'd3);
    check("t2_addr5", 64'({mem_req, mem_addr}), 64'({1'b1, 8'h05}));
    n = 0;
    while (mem_req && mem_addr == 8'h05 && n < 50) begin n++; @(negedge clk); end
    check("t2_hold5", 64'(n), 64'd3);
    check("t2_fields", 64'({insn_valid, insn_en, insn_has_imm, insn_imm, insn_reg, insn_pc}),
          64'({1'b1, 12'h008, 1'b1, 8'h7F, 3'd2, 8'h04}));
    tick(); insn_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    check("t2_next", 64'({mem_req, mem_addr}), 64'({1'b1, 8'h06}));

    // Illegal opcode at 6
    wait_valid("t4_valid");
    check("t4_illegal", 64'({insn_en, insn_illegal, insn_pc}), 64'({12'h000, 1'b1, 8'h06}));

    // Redirect while an opcode fetch awaits its ack
    park();
    wait_lo = 6; wait_hi = 6;
    redirect(8'h10);
    redirect(8'h40);
    n = 0; seen_valid = 0; @(negedge clk);
    while (mem_req && mem_addr == 8'h10 && n < 50) begin
      n++; @(negedge clk);
      if (insn_valid) seen_valid = 1;
    end
    check("t5_hold", 64'(n), 64'd5);
    check("t5_no_valid", 64'(seen_valid), 64'd0);
    check("t5_target", 64'({mem_req, mem_addr, insn_valid}), 64'({1'b1, 8'h40, 1'b0}));
    wait_lo = 0; wait_hi = 0;

    // Immediate fetch wraps past the top address
    park();
    redirect(8'hFF);
    @(negedge clk);
    check("t6_op", 64'({mem_req, mem_addr}), 64'({1'b1, 8'hFF}));
    @(negedge clk);
    check("t6_imm_wrap", 64'({mem_req, mem_addr}), 64'({1'b1, 8'h00}));
    @(negedge clk);
    check("t6_fields", 64'({insn_valid, insn_pc, insn_has_imm, insn_imm, insn_en, insn_reg}),
          64'({1'b1, 8'hFF, 1'b1, 8'h25, 12'h002, 3'd3}));
    tick(); insn_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    check("t6_next", 64'({mem_req, mem_addr}), 64'({1'b1, 8'h01}));

    // Asynchronous reset in the middle of an immediate fetch
    park();
    wait_lo = 4; wait_hi = 4;
    redirect(8'hFF);
    wait_req_addr(8'h00, "t6r_in_imm");
    #2 rst_n = 1'b0;
    #1 check("t6r_async", 64'({mem_req, insn_valid}), 64'd0);
    tick(); tick();
    wait_lo = 0; wait_hi = 0;
    rst_n = 1'b1;
    n = 0; @(negedge clk);
    while (!mem_req && n < 20) begin n++; @(negedge clk); end
    check("t6r_first_req", 64'({mem_req, mem_addr}), 64'({1'b1, RESET_PC}));

    // Random program, latency, backpressure and redirects
    tick(); rst_n = 1'b0;
    tick(); tick();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    wait_lo = 0; wait_hi = 3;
    acc0 = accepted;
    tick(); rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      insn_ready    = ($urandom_range(99, 0) < 70);
      redirect_en   = ($urandom_range(99, 0) < 4);
      redirect_addr = 8'($urandom);
    end
    tick(); redirect_en = 1'b0; insn_ready = 1'b1;
    repeat (50) tick();
    check("rand_progress", 64'((accepted - acc0) >= 100), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
